serial_adder_16_s: RTL and testbench

//   Multi-cycle signed adder/subtractor for 4*NIBBLES-bit two's-complement operands.

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_slice_4.sv | 25 ++
 rtl/serial_adder_16_s.sv | 134 +++++++++++++
 tb/tb_serial_adder_16_s.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package adder_pkg;

    localparam int unsigned NIBBLE_W    = 4;
    localparam int unsigned NIBBLES_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Index counter width; at least one bit so a single-nibble build still elaborates.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_slice_4.sv
// Combinational 4-bit add slice with carry-out and signed-overflow flag.
module adder_slice_4
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                ovf
);

    logic [NIBBLE_W:0]   full_sum;
    logic [NIBBLE_W-1:0] low_sum;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + (NIBBLE_W + 1)'(cin);
        // Sum of the lower bits only; its top bit is the carry into the MSB.
        low_sum  = {1'b0, a[NIBBLE_W-2:0]} + {1'b0, b[NIBBLE_W-2:0]} + NIBBLE_W'(cin);
        s        = full_sum[NIBBLE_W-1:0];
        cout     = full_sum[NIBBLE_W];
        ovf      = low_sum[NIBBLE_W-1] ^ full_sum[NIBBLE_W];
    end

endmodule

// File: rtl/serial_adder_16_s.sv
// Nibble-serial signed adder/subtractor with valid/ready handshakes on both sides.
module serial_adder_16_s
    import adder_pkg::*;
#(
    parameter  int unsigned NIBBLES = NIBBLES_DEF,
    localparam int unsigned W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         overflow,
    output logic         busy
);

    localparam int unsigned     IDX_W    = idx_w(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e              state_q,  state_d;
    logic [W-1:0]        a_q,      a_d;
    logic [W-1:0]        b_q,      b_d;
    logic                carry_q,  carry_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [W-1:0]        sum_q,    sum_d;
    logic                cout_q,   cout_d;
    logic                ovf_q,    ovf_d;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;

    logic [NIBBLE_W-1:0] a_nib;
    logic [NIBBLE_W-1:0] b_nib;
    logic [NIBBLE_W-1:0] s_nib;
    logic                slice_cout;
    logic                slice_ovf;

    assign a_nib = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
    assign b_nib = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

    adder_slice_4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .s    (s_nib),
        .cout (slice_cout),
        .ovf  (slice_ovf)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = s_nib;
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_ovf;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_16_s.sv
// Self-checking bench for serial_adder_16_s: vector table, scoreboard and handshake corner cases.
module tb_serial_adder_16_s;

    localparam int unsigned NIB = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        v;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        overflow;
    logic        busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_acc = -1;
    bit   chk_spacing = 1'b0;
    bit   prev_ov = 1'b0;
    exp_t sb[$];
    vec_t vecs[9];

    serial_adder_16_s #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
        exp_t        e;
        logic [15:0] yy;
        logic [16:0] t;
        yy    = s ? ~y : y;
        t     = {1'b0, x} + {1'b0, yy} + 17'(s);
        e.s   = t[15:0];
        e.c   = t[16];
        e.v   = (x[15] == yy[15]) && (t[15] != x[15]);
        e.acc = 0;
        return e;
    endfunction

    // Present one operation, push its expectation at accept, then scramble the operand bus.
    task automatic send(input logic [15:0] ai, input logic [15:0] bi, input logic si,
                        input logic [15:0] es, input logic ec, input logic ev, input bit hold);
        bit   got;
        exp_t e;
        got = 1'b0;
        @(posedge clk); #1;
        a = ai; b = bi; sub = si; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            e.s = es; e.c = ec; e.v = ev; e.acc = cyc + 1;
            sb.push_back(e);
            if (chk_spacing && last_acc >= 0) chk("accept_spacing", 32'(e.acc - last_acc), NIB + 2);
            last_acc = e.acc;
            @(posedge clk); #1;
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            if (!hold) in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard: latency on out_valid rise, result compare on output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && !prev_ov) begin
                if (sb.size() != 0) chk("latency", 32'(cyc - sb[0].acc), NIB);
                else chk("unexpected_out_valid", 32'd1, 32'd0);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
                chk("overflow", 32'(overflow), 32'(e.v));
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        exp_t m;
        logic [15:0] ra, rb;
        logic        rs;

        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[1] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[4] = '{16'h0003, 16'hFFFE, 1'b0, 16'h0001, 1'b1, 1'b0};
        vecs[5] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};

        // Reset values
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].s, vecs[i].c, vecs[i].v, 1'b0);
            drain();
        end

        // Backpressure: result held, no accepts while DONE
        out_ready = 1'b0;
        send(16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(sum), 32'h2201);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            in_valid = ~in_valid;
            a = 16'($urandom); b = 16'($urandom);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (3) @(negedge clk);
        chk("bp_no_extra_busy", 32'(busy), 32'd0);
        chk("bp_no_extra_valid", 32'(out_valid), 32'd0);

        // Reset during the second RUN cycle aborts the operation
        send(16'h4321, 16'h1111, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        send(16'h0003, 16'hFFFE, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
        drain();

        // Back-to-back with in_valid held high
        chk_spacing = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            if (i == 0) begin ra = 16'h7FFF; rb = 16'h0001; rs = 1'b0; end
            m = model(ra, rb, rs);
            send(ra, rb, rs, m.s, m.c, m.v, (i != 7));
        end
        chk_spacing = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
